// File: rtl/cache_pkg.sv
// Shared cache address helpers: field widths, the default address layout and way-index sizing.
package cache_pkg;

  function automatic int unsigned offset_width(input int unsigned block_size);
    return (block_size > 8) ? $clog2(block_size / 8) : 0;
  endfunction

  function automatic int unsigned set_width(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int unsigned tag_width(input int unsigned addr_size,
                                            input int unsigned num_sets,
                                            input int unsigned block_size);
    return addr_size - set_width(num_sets) - offset_width(block_size);
  endfunction

  function automatic int unsigned way_width(input int unsigned num_ways);
    return (num_ways > 2) ? $clog2(num_ways) : 1;
  endfunction

  localparam int unsigned CACHE_ADDR_SIZE  = 32;
  localparam int unsigned CACHE_NUM_SETS   = 16;
  localparam int unsigned CACHE_BLOCK_SIZE = 32;
  localparam int unsigned CACHE_NUM_WAYS   = 4;

  localparam int unsigned CACHE_OFF_W = offset_width(CACHE_BLOCK_SIZE);
  localparam int unsigned CACHE_SET_W = set_width(CACHE_NUM_SETS);
  localparam int unsigned CACHE_TAG_W = tag_width(CACHE_ADDR_SIZE, CACHE_NUM_SETS, CACHE_BLOCK_SIZE);
  localparam int unsigned CACHE_WAY_W = way_width(CACHE_NUM_WAYS);

  typedef struct packed {
    logic [CACHE_TAG_W-1:0] tag;
    logic [CACHE_SET_W-1:0] set_idx;
    logic [CACHE_OFF_W-1:0] byte_offset;
  } cache_addr_t;

endpackage

// File: rtl/plru_tree.sv
// Combinational pseudo-LRU tree for one set: walks the heap-ordered bits to the victim leaf
// and produces the bits after touching a given way (path nodes point away from it).
module plru_tree
  import cache_pkg::*;
#(
  parameter int unsigned NUM_WAYS = 4,
  localparam int unsigned WAY_W = way_width(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0] i_bits,
  input  logic [WAY_W-1:0]    i_touch_way,
  output logic [WAY_W-1:0]    o_victim,
  output logic [NUM_WAYS-2:0] o_next_bits
);

  localparam int unsigned LEVELS = $clog2(NUM_WAYS);

  always_comb begin
    int node;
    o_victim = '0;
    node     = 0;
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      o_victim[LEVELS-1-lvl] = i_bits[node];
      node = 2 * node + (i_bits[node] ? 2 : 1);
    end
  end

  // The root decides the way MSB, so the touched way is walked MSB first.
  always_comb begin
    int node;
    o_next_bits = i_bits;
    node        = 0;
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      o_next_bits[node] = ~i_touch_way[LEVELS-1-lvl];
      node = 2 * node + (i_touch_way[LEVELS-1-lvl] ? 2 : 1);
    end
  end

endmodule

// File: rtl/plru_cru.sv
// Tree pseudo-LRU replacement unit: per-set tree state, combinational victim, replace-over-access updates.
// Optional PLRU_INVALID_FIRST_EN: adds valid_mask and prefers the lowest invalid way as victim.
module plru_cru
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = 32,
  parameter int unsigned NUM_SETS   = 16,
  parameter int unsigned BLOCK_SIZE = 32,
  parameter int unsigned NUM_WAYS   = 4,
  localparam int unsigned WAY_W = way_width(NUM_WAYS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic                 access,
  input  logic [WAY_W-1:0]     access_way,
  input  logic                 replace,
`ifdef PLRU_INVALID_FIRST_EN
  input  logic [NUM_WAYS-1:0]  valid_mask,
`endif
  output logic [WAY_W-1:0]     victim
);

  localparam int unsigned OFF_W = offset_width(BLOCK_SIZE);
  localparam int unsigned SET_W = set_width(NUM_SETS);
  localparam int unsigned NODES = NUM_WAYS - 1;

  logic [NODES-1:0] r_tree [NUM_SETS];

  logic [SET_W-1:0] w_set;
  logic [NODES-1:0] w_bits;
  logic [NODES-1:0] w_next_bits;
  logic [WAY_W-1:0] w_tree_victim;
  logic [WAY_W-1:0] w_victim;
  logic [WAY_W-1:0] w_touch_way;
  logic             w_update;
  logic             w_unused_addr;

  // Tag and byte-offset bits do not take part in replacement.
  assign w_unused_addr = ^addr;
  assign w_set         = addr[OFF_W +: SET_W];
  assign w_bits        = r_tree[w_set];

  plru_tree #(
    .NUM_WAYS (NUM_WAYS)
  ) u_tree (
    .i_bits      (w_bits),
    .i_touch_way (w_touch_way),
    .o_victim    (w_tree_victim),
    .o_next_bits (w_next_bits)
  );

`ifdef PLRU_INVALID_FIRST_EN
  always_comb begin
    w_victim = w_tree_victim;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!valid_mask[i]) begin
        w_victim = WAY_W'(i);
      end
    end
  end
`else
  assign w_victim = w_tree_victim;
`endif

  // A fill consumes the reported victim and wins over a same-cycle hit.
  assign w_touch_way = replace ? w_victim : access_way;
  assign w_update    = replace | access;
  assign victim      = w_victim;

  generate
    for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_set
      always_ff @(posedge clk) begin
        if (rst) begin
          r_tree[gi] <= '0;
        end else if (w_update && (w_set == SET_W'(gi))) begin
          r_tree[gi] <= w_next_bits;
        end
      end
    end
  endgenerate

endmodule

// File: doc/plru_cru.md
# plru_cru

Tree pseudo-LRU cache replacement unit for an N-way set-associative cache; the parametrised successor of the two-way LRU replacement unit. It holds NUM_WAYS−1 tree bits per set, presents the victim way for the addressed set combinationally, and updates the set's tree on every access (hit) or replacement (fill). It sits beside the cache tag/data arrays and is driven by the cache controller FSM.

## Interface
- ADDR_SIZE, 32, byte address width
- NUM_SETS, 16, number of sets; power of two, ≥2
- BLOCK_SIZE, 32, line size in bits; power of two, ≥8
- NUM_WAYS, 4, associativity; power of two, 2..16
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- addr  in  ADDR_SIZE  address of current lookup; selects set
- access  in  1  hit on access_way this cycle; mark it most-recent
- access_way  in  $clog2(NUM_WAYS)  way that hit
- replace  in  1  line fill this cycle into victim; mark victim most-recent
- valid_mask  in  NUM_WAYS  per-way valid bits of addressed set (only with PLRU_INVALID_FIRST_EN)
- victim  out  $clog2(NUM_WAYS)  way to evict for addressed set

## Operation
- Address split, LSB first: byte offset = $clog2(BLOCK_SIZE/8) bits, set = $clog2(NUM_SETS) bits, tag = remainder. Only set is used.
- State: NUM_SETS × (NUM_WAYS−1) tree bits, heap-indexed: node 0 = root, children of node i are 2i+1 (lower ways) and 2i+2 (upper ways).
- Node bit 0 = victim lies in lower half; 1 = upper half. Victim = leaf reached by walking from root following bits.
- Touch(w): every node on the path to w is set to point away from w (set to 1 if w is in its lower half, 0 otherwise). Other nodes are unchanged; other sets are unchanged.
- Priority per cycle, one update max: rst > replace > access. replace touches the current victim; access touches access_way. Both asserted: only the replace update is applied, access is dropped.
- access and replace both low: state holds.
- NUM_WAYS=2 degenerates to one bit per set; victim toggles away from each touched way.
- rst clears every tree bit of every set in one cycle (not just the addressed set); victim reads 0 for all sets afterwards.

## Timing
- victim is combinational from addr and current state: valid in the same cycle addr is stable, no pipeline.
- Updates land on the next rising edge; victim reflects them from the following cycle.
- Back-to-back touches to the same set in consecutive cycles apply in order; no stall, no hazard.
- rst asserted mid-sequence: access/replace in that cycle are ignored; state is all-zero next cycle.
- Output reset value: victim = 0 for every addr.

## Configuration
- PLRU_INVALID_FIRST_EN defined: valid_mask port exists; if any bit of valid_mask is 0, victim = lowest-index invalid way, else tree victim. replace touches that reported victim.
- Not defined: valid_mask port absent; victim always from the tree.

## Structure
- Shared package cache_pkg: address-field width functions/localparams, cache_addr_t packed struct (tag, set, byte_offset, MSB to LSB), way-index type width helper.
- One sub-module plru_tree: combinational, one set's NUM_WAYS−1 bits in, producing tree victim and the next-state bits for a given touched way; plru_cru instantiates it once on the addressed set's bits and owns the state array and priority muxing.

## Test plan
- NUM_WAYS=4: rst one cycle -> victim 0 for set 0 and set 15.
- Set 3: access way 0 -> victim 2; access way 2 -> victim 1; access way 1 -> victim 3.
- Set 3 after the above, access on set 5 way 1 -> set 3 victim still 3, set 5 victim 2.
- Set 0 from reset: replace and access way 0 same cycle -> replace wins, touches way 0, victim 2; repeat replace four times -> victims 2, 1, 3, 0 in sequence.
- Mid-sequence rst with access high -> all sets victim 0 next cycle, access ignored.
- PLRU_INVALID_FIRST_EN, valid_mask 4'b1011 -> victim 2; replace -> tree touched at way 2; valid_mask 4'b1111 -> victim 1.
